// File: rtl/parity_pkg.sv
// Shared parity definitions for the stream checker and related status blocks.
// parity_err() is width-generic: callers zero-extend to PARITY_MAX_W, which leaves XOR parity unchanged.
package parity_pkg;

  localparam logic PARITY_EVEN  = 1'b0;
  localparam logic PARITY_ODD   = 1'b1;
  localparam int   PARITY_MAX_W = 256;

  typedef enum logic {
    OCC_EMPTY = 1'b0,
    OCC_FULL  = 1'b1
  } occ_state_t;

  // 1 when the received parity bit disagrees with the expected even/odd sense.
  function automatic logic parity_err(input logic [PARITY_MAX_W-1:0] data,
                                      input logic                    parity,
                                      input logic                    mode);
    return (^data) ^ parity ^ mode;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear-then-increment when both are set.
// Latency 1 cycle; no backpressure, inc is sampled every cycle.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_ONE : '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming parity checker with one-entry registered output and sticky/counted error status (counter under PARITY_ERR_CNT_EN).
// Latency 1 cycle accept->out_valid; in_ready = !out_valid | out_ready, so full throughput and a stall holds the output.
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_odd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_error,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_err
);

  occ_state_t              state_q;
  occ_state_t              state_d;
  logic                    accept;
  logic                    word_err;
  logic [PARITY_MAX_W-1:0] data_ext;

  assign data_ext = PARITY_MAX_W'(in_data);
  assign word_err = parity_err(data_ext, in_parity, mode_odd);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (accept) state_d = OCC_FULL;
      OCC_FULL:  if (!accept && out_ready) state_d = OCC_EMPTY;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == OCC_FULL);
    in_ready  = (state_q == OCC_EMPTY) | out_ready;
  end

  // Payload/error register only loads on accept, so it holds through stalls and after drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_error <= 1'b0;
    end else if (accept) begin
      out_data  <= in_data;
      out_error <= word_err;
    end
  end

  // An erroneous accept wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (accept && word_err) begin
      err_sticky <= 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_err),
    .inc   (accept & word_err),
    .count (err_count)
  );
`else
  assign err_count = '0;
`endif

endmodule
